// File: rtl/game_pkg.sv
// Shared game constants: play-field geometry, pixel colours and the renderer state type.
package game_pkg;

    localparam int NUM_COLS = 40;
    localparam int COL_W    = 4;
    localparam int PLAY_H   = 80;
    localparam int Y_BASE   = 84;
    localparam int GAP      = 12;
    localparam int BIRD_W   = 2;
    localparam int BIRD_H   = 4;

    localparam logic [2:0] COL_BG   = 3'b011;
    localparam logic [2:0] COL_PIPE = 3'b110;
    localparam logic [2:0] COL_BIRD = 3'b100;

    typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;

endpackage

// File: rtl/pixel_classify.sv
// Combinational pixel classifier: decides bird / pipe / background for one play-field pixel.
module pixel_classify
    import game_pkg::*;
#(
    parameter int BIRD_W = game_pkg::BIRD_W,
    parameter int BIRD_H = game_pkg::BIRD_H,
    parameter int GAP    = game_pkg::GAP
) (
    input  logic [7:0] sx,
    input  logic [6:0] row,
    input  logic [6:0] bird_q,
    input  logic [6:0] pipe_q,
    output logic [2:0] colour,
    output logic       is_bird,
    output logic       is_pipe
);

    logic [7:0] row8;
    logic [7:0] bird_top;
    logic [7:0] pipe_top;

    // Extended to 8 bits so the tops of the bird and the gap never wrap.
    assign row8     = {1'b0, row};
    assign bird_top = {1'b0, bird_q} + 8'(BIRD_H - 1);
    assign pipe_top = {1'b0, pipe_q} + 8'(GAP);

    assign is_bird = (sx < 8'(BIRD_W)) && (row8 >= {1'b0, bird_q}) && (row8 <= bird_top);
    assign is_pipe = (pipe_q != 7'd0) && ((row < pipe_q) || (row8 > pipe_top));

    always_comb begin
        colour = COL_BG;
        if (is_bird) begin
            colour = COL_BIRD;
        end else if (is_pipe) begin
            colour = COL_PIPE;
        end
    end

endmodule

// File: rtl/pipe_renderer.sv
// Frame scanner: walks the pipe column buffer and emits one registered pixel per cycle,
// drawing the bird over the pipes and recording whether the two overlapped.
module pipe_renderer
    import game_pkg::*;
#(
    parameter int NUM_COLS = game_pkg::NUM_COLS,
    parameter int COL_W    = game_pkg::COL_W,
    parameter int PLAY_H   = game_pkg::PLAY_H,
    parameter int Y_BASE   = game_pkg::Y_BASE,
    parameter int GAP      = game_pkg::GAP,
    parameter int BIRD_W   = game_pkg::BIRD_W,
    parameter int BIRD_H   = game_pkg::BIRD_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_go,
    input  logic [6:0] bird_height,
    output logic [5:0] col_rd_addr,
    input  logic [6:0] col_rd_data,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       hit
);

    localparam int PXW = (COL_W > 1) ? $clog2(COL_W) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       c;
    logic [5:0]       c_nxt;
    logic [PXW-1:0]   px;
    logic [6:0]       row;
    logic [6:0]       bird_q;
    logic [6:0]       pipe_q;
    logic             hit_acc;
    logic             hit_acc_nxt;
    logic             last_pix;
    logic             last_col;
    logic [7:0]       sx;
    logic [2:0]       pix_colour;
    logic             is_bird;
    logic             is_pipe;

    assign last_pix    = (px == PXW'(COL_W - 1)) && (row == 7'(PLAY_H - 1));
    assign last_col    = (c == 6'(NUM_COLS - 1));
    assign sx          = 8'(c) * 8'(COL_W) + 8'(px);
    assign hit_acc_nxt = hit_acc | (is_bird & is_pipe);

    pixel_classify #(
        .BIRD_W (BIRD_W),
        .BIRD_H (BIRD_H),
        .GAP    (GAP)
    ) u_classify (
        .sx      (sx),
        .row     (row),
        .bird_q  (bird_q),
        .pipe_q  (pipe_q),
        .colour  (pix_colour),
        .is_bird (is_bird),
        .is_pipe (is_pipe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        case (state)
            IDLE: begin
                if (frame_go) begin
                    state_nxt = FETCH;
                    c_nxt     = 6'd0;
                end
            end
            FETCH: state_nxt = DRAW;
            DRAW: begin
                if (last_pix) begin
                    if (last_col) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                        c_nxt     = c + 6'd1;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The read address runs one cycle ahead of c so the synchronous buffer
    // already holds the column's data during the single FETCH cycle.
    always_comb begin
        col_rd_addr = c_nxt;
        busy        = (state != IDLE);
        frame_done  = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c       <= '0;
            px      <= '0;
            row     <= '0;
            bird_q  <= '0;
            pipe_q  <= '0;
            hit_acc <= 1'b0;
            hit     <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
        end else begin
            c    <= c_nxt;
            plot <= (state == DRAW);
            case (state)
                IDLE: begin
                    if (frame_go) begin
                        bird_q  <= bird_height;
                        hit_acc <= 1'b0;
                    end
                end
                FETCH: begin
                    pipe_q <= col_rd_data;
                    px     <= '0;
                    row    <= '0;
                end
                DRAW: begin
                    x       <= sx;
                    y       <= 7'(Y_BASE) - row;
                    colour  <= pix_colour;
                    hit_acc <= hit_acc_nxt;
                    if (row == 7'(PLAY_H - 1)) begin
                        row <= '0;
                        px  <= px + PXW'(1);
                    end else begin
                        row <= row + 7'd1;
                    end
                    // Publish on entry to DONE so hit is valid alongside frame_done.
                    if (last_pix && last_col) begin
                        hit <= hit_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_renderer.sv
// Self-checking bench for pipe_renderer: directed frames plus a randomized frame,
// each pixel compared against a per-pixel reference model of the play field.
module tb_pipe_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_go;
    logic [6:0] bird_height;
    logic [5:0] col_rd_addr;
    logic [6:0] col_rd_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;
    logic       hit;

    logic [6:0] colbuf [64];
    int         n_assert = 0;
    int         n_fail   = 0;

    pipe_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_go    (frame_go),
        .bird_height (bird_height),
        .col_rd_addr (col_rd_addr),
        .col_rd_data (col_rd_data),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .frame_done  (frame_done),
        .hit         (hit)
    );

    always #5 clk = ~clk;

    // Column buffer with synchronous read, one cycle of latency.
    always @(posedge clk) col_rd_data <= colbuf[col_rd_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_colour(input int xs, input int row, input int bh, input int ph);
        bit bird;
        bit pipe;
        bird = (xs < 2) && (row >= bh) && (row < bh + 4);
        pipe = (ph != 0) && ((row < ph) || (row > ph + 12));
        if (bird) return 3'b100;
        if (pipe) return 3'b110;
        return 3'b011;
    endfunction

    function automatic logic ref_hit(input int bh);
        int ph;
        ph = colbuf[0];
        for (int r = 0; r < 80; r++) begin
            if (r >= bh && r < bh + 4 && ph != 0 && (r < ph || r > ph + 12)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Runs one frame. regate_at pulses frame_go and alters bird_height mid-frame;
    // abort_at asserts reset at that cycle; go_at_done pulses frame_go during DONE.
    task automatic run_frame(input int bh, input int regate_at, input int new_bh,
                             input int abort_at, input bit go_at_done);
        int   k;
        int   col;
        int   px;
        int   row;
        bit   done_seen;
        logic exp_hit;
        k         = 0;
        done_seen = 1'b0;
        exp_hit   = ref_hit(bh);
        bird_height = 7'(bh);
        frame_go    = 1'b1;
        for (int n = 1; n <= 13000 && !done_seen; n++) begin
            @(posedge clk);
            #1;
            frame_go = 1'b0;
            if (n == 1) check_eq("busy_after_go", busy, 1);
            if (n == regate_at) begin
                frame_go    = 1'b1;
                bird_height = 7'(new_bh);
            end
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                check_eq("abort_plot", plot, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_hit", hit, 0);
                check_eq("abort_done", frame_done, 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (plot) begin
                col = k / 320;
                px  = (k % 320) / 80;
                row = k % 80;
                if (k < 12800) begin
                    check_eq("pixel_xyc", {x, y, colour},
                             {8'(col * 4 + px), 7'(84 - row),
                              ref_colour(col * 4 + px, row, bh, int'(colbuf[col]))});
                end
                k++;
            end
            if (frame_done) begin
                done_seen = 1'b1;
                check_eq("done_cycle", n, 12841);
                check_eq("plot_count", k, 12800);
                check_eq("hit", hit, exp_hit);
                check_eq("busy_in_done", busy, 1);
                if (go_at_done) frame_go = 1'b1;
            end
        end
        if (!done_seen) check_eq("frame_done_timeout", 0, 1);
        @(posedge clk);
        #1;
        frame_go = 1'b0;
        check_eq("idle_after_done", busy, 0);
        check_eq("no_second_done", frame_done, 0);
        check_eq("hit_held", hit, exp_hit);
    endtask

    initial begin
        reset       = 1'b1;
        frame_go    = 1'b0;
        bird_height = 7'd0;
        for (int i = 0; i < 64; i++) colbuf[i] = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_x", x, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_colour", colour, 0);
        check_eq("rst_plot", plot, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_addr", col_rd_addr, 0);

        // Empty buffer; a frame_go during DONE must be ignored.
        run_frame(10, 0, 0, 0, 1'b1);

        // Collision frame started straight from the post-DONE idle cycle,
        // with a mid-frame re-request and bird_height change.
        colbuf[0] = 7'd30;
        colbuf[5] = 7'd20;
        run_frame(28, 5000, 60, 0, 1'b0);

        // Reset mid-frame clears the previous hit and aborts the frame.
        run_frame(28, 0, 0, 3000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_abort_busy", busy, 0);
        check_eq("post_abort_plot", plot, 0);

        // Bird just above the pipe opening floor: no hit.
        run_frame(31, 0, 0, 0, 1'b0);

        // Randomized buffer and bird height, including off-screen heights.
        for (int i = 0; i < 40; i++) begin
            colbuf[i] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 79));
        end
        run_frame(int'($urandom_range(0, 95)), 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
